byte_capture_fifo: RTL and testbench
====================================

# byte_capture_fifo

Downstream consumer of the 8-bit processing stage: samples its `data_out` byte whenever its `valid` strobe is high and buffers it in a small FIFO for a ready/valid consumer. The producing stage has no backpressure, so bytes arriving while the FIFO is full are dropped, counted, and flagged. It is the capture point that decouples the free-running datapath from a stalling sink.

## Interface
- `WIDTH`, 8: byte width; matches the upstream `data_out` bus.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input WIDTH: upstream `data_out`.
- `in_valid` input 1: upstream `valid`; a byte is offered on every cycle it is high.
- `out_data` output WIDTH: head-of-FIFO byte.
- `out_valid` output 1: head entry present.
- `out_ready` input 1: consumer accepts the head when `out_valid & out_ready`.
- `count` output $clog2(DEPTH+1): current occupancy.
- `full` output 1: `count == DEPTH`.
- `empty` output 1: `count == 0`.
- `overflow` output 1: sticky; set when any byte is dropped.
- `clr_ovf` input 1: clears `overflow` and `drop_cnt`.
- `drop_cnt` output 8: saturating count of dropped bytes.

## Operation
- push = `in_valid & (~full | pop)`; pop = `out_valid & out_ready`; drop = `in_valid & full & ~pop`.
- Storage is a circular buffer with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits and wrapping DEPTH-1 -> 0. `count` is held as an explicit register, not derived from the pointers.
- Occupancy update: push only gives +1; pop only gives -1; push and pop together leave `count` unchanged.
- Full with simultaneous pop: the incoming byte is accepted and not dropped. `full` stays high.
- Empty with push: the byte is not visible the same cycle; there is no fall-through.
- Drop behaviour: `overflow` is set to 1 and `drop_cnt` increments, saturating at 255.
- `clr_ovf` in the same cycle as a drop: the clear wins. Result is `overflow` = 0 and `drop_cnt` = 0.
- `out_data` is `mem[rp]` and is valid only while `out_valid`. When empty, its value is don't-care but must not be X after reset; memory is reset to 0.
- `out_valid` is equivalent to `~empty`.
- Reset values:
  - `wp`, `rp` and `count` = 0.
  - `empty` = 1; `full`, `out_valid` and `overflow` = 0.
  - `drop_cnt` = 0; `out_data` = 0.
- Reset in the middle of a transfer discards all contents. A push or pop in the reset cycle is ignored.

## Timing
- Capture latency: a byte with `in_valid` high in cycle N is at `out_data` with `out_valid` high in cycle N+1, provided the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained indefinitely at steady occupancy.
- Status outputs `full`, `empty`, `count`, `overflow` and `drop_cnt` are registered. They reflect the state after the previous edge.
- `out_ready` may toggle freely. `out_data` holds stable while `out_valid & ~out_ready`.
- No combinational path from `in_valid` or `in_data` to any output. The only combinational input-to-state dependency is from `out_ready` into the push-accept decision when full.

## Structure
- Shared package `capture_pkg`:
  - `BYTE_W` = 8
  - `DROP_CNT_W` = 8
  - `DROP_CNT_MAX` = 8'hFF
  - typedef `byte_t` (logic [BYTE_W-1:0])
- One sub-module, `capture_mem`: DEPTH x WIDTH register array with one synchronous write port (`we`, `waddr`, `wdata`), one combinational read port (`raddr`, `rdata`), and synchronous reset to 0.
- Pointer, count and overflow logic live in `byte_capture_fifo`.

## Test plan
- Reset, then single push: `rst`=1 for 2 cycles; `in_data`=8'hA5 with `in_valid`=1 for 1 cycle. Next cycle: `out_valid`=1, `out_data`=8'hA5, `count`=1. With `out_ready`=1: `empty`=1 one cycle later.
- Fill and order: `out_ready`=0; push 8'h01..8'h04. Result: `full`=1, `count`=4. Drain with `out_ready`=1: bytes 01, 02, 03, 04 appear in order on consecutive cycles, then `empty`=1.
- Overflow: FIFO full, `out_ready`=0; push 8'h05 and 8'h06. Result: `overflow`=1, `drop_cnt`=2, and the contents are still 01..04. Pulse `clr_ovf`: both return to 0.
- Full with simultaneous push and pop: full with 01..04; `in_valid`=1, `in_data`=8'h07, `out_ready`=1. Result: `drop_cnt` unchanged, `count`=4, and the drained sequence is 02, 03, 04, 07.
- Wrap-around and saturation:
  - Stream 20 bytes with `out_ready`=1 every cycle: the output is identical to the input, delayed by 1 cycle, with `count` ≤ 1.
  - Then hold full and offer 300 bytes: `drop_cnt`=255.
- Mid-operation reset: with `count`=3, assert `rst` in the same cycle as a push and a pop. Next cycle: `count`=0, `empty`=1, `overflow`=0.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg
// Shared types and constants for the byte capture FIFO.
//   BYTE_W        - width of one captured byte
//   DROP_CNT_W    - width of the dropped-byte counter
//   DROP_CNT_MAX  - saturation value of the dropped-byte counter
//   byte_t        - one captured byte
//   sat_inc_drop  - saturating increment for the drop counter
package capture_pkg;

    localparam int BYTE_W     = 8;
    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

    typedef logic [BYTE_W-1:0] byte_t;

    // Increment that sticks at DROP_CNT_MAX instead of wrapping to zero.
    function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] val);
        if (val == DROP_CNT_MAX) begin
            return val;
        end
        return val + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/byte_capture_fifo_if.sv
// byte_capture_fifo_if
// Bundles the capture-side input, the ready/valid consumer side and the
// status/overflow signals of the byte capture FIFO.
//   master modport: producer/consumer/controller side (drives in_*, out_ready, clr_ovf)
//   slave  modport: the FIFO itself (drives out_*, count, full, empty, overflow, drop_cnt)
interface byte_capture_fifo_if
    import capture_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]             in_data;
    logic                         in_valid;
    logic [WIDTH-1:0]             out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;
    logic                         empty;
    logic                         overflow;
    logic                         clr_ovf;
    logic [DROP_CNT_W-1:0]        drop_cnt;

    modport master (
        output in_data, in_valid, out_ready, clr_ovf,
        input  out_data, out_valid, count, full, empty, overflow, drop_cnt
    );

    modport slave (
        input  in_data, in_valid, out_ready, clr_ovf,
        output out_data, out_valid, count, full, empty, overflow, drop_cnt
    );
endinterface

// File: rtl/byte_capture_fifo_mem.sv
// capture_mem
// DEPTH x WIDTH register array backing the capture FIFO.
//   clk, rst      - clock and synchronous active-high reset (clears every entry)
//   we/waddr/wdata- synchronous write port
//   raddr/rdata   - combinational read port (head byte is visible without a cycle of latency)
module capture_mem
    import capture_pkg::*;
#(
    parameter int WIDTH  = BYTE_W,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // One flop group per entry; clearing on reset keeps the read port free of X.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (rst) begin
                mem_q[gi] <= '0;
            end else if (we && (waddr == ADDR_W'(gi))) begin
                mem_q[gi] <= wdata;
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/byte_capture_fifo.sv
// byte_capture_fifo
// Captures every byte offered by a free-running upstream stage (in_valid has
// no backpressure) into a small circular FIFO drained by a ready/valid sink.
// Bytes arriving while full (and not freed by a same-cycle pop) are dropped,
// counted in a saturating counter and flagged by a sticky overflow bit.
//   clk, rst  - clock and synchronous active-high reset
//   bus.slave - in_data/in_valid capture input, out_data/out_valid/out_ready
//               consumer port, count/full/empty status, overflow/drop_cnt/clr_ovf
module byte_capture_fifo
    import capture_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    byte_capture_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]      wp_q, wp_d;
    logic [PTR_W-1:0]      rp_q, rp_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [WIDTH-1:0]      head_data;

    // A pop frees the slot the incoming byte needs, so a full FIFO still
    // accepts when the sink takes the head in the same cycle.
    always_comb begin
        pop  = ~empty_q & bus.out_ready;
        push = bus.in_valid & (~full_q | pop);
        drop = bus.in_valid & full_q & ~pop;
    end

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        // Power-of-two depth: natural pointer overflow is the wrap.
        if (push) begin
            wp_d = wp_q + PTR_W'(1);
        end
        if (pop) begin
            rp_d = rp_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear has priority over a drop in the same cycle.
        if (bus.clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc_drop(drop_cnt_q);
        end

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    capture_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wp_q),
        .wdata (bus.in_data),
        .raddr (rp_q),
        .rdata (head_data)
    );

    assign bus.out_data  = head_data;
    assign bus.out_valid = ~empty_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.overflow  = overflow_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_byte_capture_fifo.sv
// tb_byte_capture_fifo
// Drives the byte capture FIFO one cycle at a time while a queue-based model
// tracks the expected contents, overflow flag and drop count.
module tb_byte_capture_fifo;
    import capture_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    byte_capture_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();

    byte_capture_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_drop;
    int         n_checks;
    int         n_fail;
    int         ncyc;

    // One clock of stimulus; the model advances using the pre-edge state.
    task automatic cycle(input bit v, input logic [7:0] d, input bit rdy, input bit clr, input bit r);
        bit pop, full, acc, drop;
        logic [7:0] tmp;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        rst           = r;
        pop  = (mq.size() > 0) && rdy;
        full = (mq.size() == DEPTH);
        acc  = v && (!full || pop);
        drop = v && full && !pop;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            if (pop) tmp = mq.pop_front();
            if (acc) mq.push_back(d);
            if (clr) begin
                m_ovf  = 0;
                m_drop = 0;
            end else if (drop) begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
        ncyc++;
        $display("cyc %0d rst=%0b v=%0b d=%02h rdy=%0b clr=%0b -> cnt=%0d ov=%0b dc=%0d od=%02h",
                 ncyc, r, v, d, rdy, clr, bus.count, bus.overflow, bus.drop_cnt, bus.out_data);
    endtask

    task automatic test_reset();
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 0);
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        n_checks++; if (bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt); end
        n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    endtask

    task automatic test_single_push();
        cycle(1, 8'hA5, 0, 0, 0);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'hA5) begin n_fail++; $display("FAIL single_out_data: got %h want a5", bus.out_data); end
        n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", bus.count); end
        cycle(0, 8'h00, 1, 0, 0);
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_fill_order();
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0, 0);
        n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", bus.full); end
        n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", bus.count); end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (bus.out_data !== 8'(i) || bus.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL drain_order: got %h/%b want %h/1", bus.out_data, bus.out_valid, 8'(i));
            end
            cycle(0, 8'h00, 1, 0, 0);
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0, 0);
        cycle(1, 8'h05, 0, 0, 0);
        cycle(1, 8'h06, 0, 0, 0);
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
        n_checks++; if (bus.drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d want 2", bus.drop_cnt); end
        n_checks++; if (bus.out_data !== 8'h01 || bus.count !== 3'd4) begin n_fail++; $display("FAIL ovf_head: got %h/%0d want 01/4", bus.out_data, bus.count); end
        cycle(0, 8'h00, 0, 1, 0);
        n_checks++; if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_clear: got %b/%0d want 0/0", bus.overflow, bus.drop_cnt); end
        // Drop and clear in the same cycle: clear wins.
        cycle(1, 8'h08, 0, 1, 0);
        n_checks++; if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_clear_wins: got %b/%0d want 0/0", bus.overflow, bus.drop_cnt); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h02; exp_seq[1] = 8'h03; exp_seq[2] = 8'h04; exp_seq[3] = 8'h07;
        cycle(1, 8'h07, 1, 0, 0);
        n_checks++; if (bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL fpp_drop_cnt: got %0d want 0", bus.drop_cnt); end
        n_checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1) begin n_fail++; $display("FAIL fpp_count: got %0d/%b want 4/1", bus.count, bus.full); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.out_data !== exp_seq[i]) begin n_fail++; $display("FAIL fpp_order: got %h want %h", bus.out_data, exp_seq[i]); end
            cycle(0, 8'h00, 1, 0, 0);
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_stream();
        logic [7:0] d;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            cycle(1, d, 1, 0, 0);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.count > 3'd1) begin
                n_fail++; $display("FAIL stream: got %h/%b/%0d want %h/1/<=1", bus.out_data, bus.out_valid, bus.count, d);
            end
        end
        cycle(0, 8'h00, 1, 0, 0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) cycle(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 300; i++) cycle(1, 8'($urandom), 0, 0, 0);
        n_checks++; if (bus.drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_drop_cnt: got %0d want 255", bus.drop_cnt); end
        n_checks++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin n_fail++; $display("FAIL sat_state: got %b/%0d want 1/4", bus.overflow, bus.count); end
        cycle(0, 8'h00, 0, 1, 0);
        n_checks++; if (bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clear: got %0d want 0", bus.drop_cnt); end
    endtask

    task automatic test_mid_reset();
        cycle(1, 8'h11, 0, 0, 0);   // drop while full
        cycle(0, 8'h00, 1, 0, 0);   // pop one
        n_checks++; if (bus.count !== 3'd3 || bus.overflow !== 1'b1) begin n_fail++; $display("FAIL mrst_pre: got %0d/%b want 3/1", bus.count, bus.overflow); end
        cycle(1, 8'h22, 1, 0, 1);
        n_checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL mrst_count: got %0d/%b want 0/1", bus.count, bus.empty); end
        n_checks++; if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mrst_ovf: got %b/%0d want 0/0", bus.overflow, bus.drop_cnt); end
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin n_fail++; $display("FAIL mrst_out: got %b/%h want 0/00", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
            n_checks++;
            if (bus.count !== 3'(mq.size()) || bus.full !== (mq.size() == DEPTH) ||
                bus.empty !== (mq.size() == 0) || bus.out_valid !== (mq.size() != 0)) begin
                n_fail++; $display("FAIL rand_status: got cnt=%0d f=%b e=%b v=%b want cnt=%0d", bus.count, bus.full, bus.empty, bus.out_valid, mq.size());
            end
            n_checks++;
            if (bus.overflow !== m_ovf || bus.drop_cnt !== 8'(m_drop)) begin
                n_fail++; $display("FAIL rand_ovf: got %b/%0d want %b/%0d", bus.overflow, bus.drop_cnt, m_ovf, m_drop);
            end
            if (mq.size() != 0) begin
                n_checks++;
                if (bus.out_data !== mq[0]) begin n_fail++; $display("FAIL rand_data: got %h want %h", bus.out_data, mq[0]); end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ncyc     = 0;
        m_ovf    = 0;
        m_drop   = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        test_reset();
        test_single_push();
        test_fill_order();
        test_overflow();
        test_full_push_pop();
        test_stream();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
